// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency line-wide memory port between
// the I-cache refill path and the D-cache refill/writeback path.
module cache_mem_arbiter #(
  parameter int LINE_W      = 128,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dc
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } stateT;

  localparam logic [7:0] CNT_INIT = 8'(MEM_LATENCY - 1);

  stateT             state;
  stateT             stateNext;
  logic [7:0]        cnt;
  logic              grantFire;
  logic              pickDc;
  logic              grantDc;
  logic              cmdWe;
  logic [ADDR_W-1:0] cmdAddr;
  logic [LINE_W-1:0] cmdWdata;
  logic [LINE_W-1:0] icRdata;
  logic [LINE_W-1:0] dcRdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    stateNext = state;
    grantFire = 1'b0;
    pickDc    = grantDc;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          grantFire = 1'b1;
          // On a tie the pointer flips; a lone requester simply wins.
          pickDc    = (ic_req && dc_req) ? !grantDc : dc_req;
          stateNext = BUSY;
        end
      end
      BUSY:    if (cnt == 8'd0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= 8'd0;
      grantDc  <= 1'b0;
      cmdWe    <= 1'b0;
      cmdAddr  <= '0;
      cmdWdata <= '0;
      icRdata  <= '0;
      dcRdata  <= '0;
    end else if (grantFire) begin
      cnt      <= CNT_INIT;
      grantDc  <= pickDc;
      cmdWe    <= pickDc && dc_we;
      cmdAddr  <= pickDc ? dc_addr : ic_addr;
      cmdWdata <= pickDc ? dc_wdata : '0;
    end else if (state == BUSY) begin
      if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else if (!cmdWe) begin
        // Read data is only valid on the final window cycle; only the owner's line moves.
        if (grantDc) dcRdata <= mem_rdata;
        else         icRdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = (state == BUSY) && cmdWe;
  assign mem_addr  = cmdAddr;
  assign mem_wdata = cmdWdata;
  assign ic_ready  = (state == RESP) && !grantDc;
  assign dc_ready  = (state == RESP) && grantDc;
  assign busy      = (state != IDLE);
  assign grant_dc  = grantDc;
  assign ic_rdata  = icRdata;
  assign dc_rdata  = dcRdata;

endmodule
